serial_frame_rx: RTL and testbench
==================================

// Module: serial_frame_rx
// PURPOSE
//   Downstream consumer of the single-bit async-reset flop stage: takes the registered serial
//   bit (qout of that flop) on din and deframes it. Frame: 1 start bit (0), DATA_W data bits
//   LSB first, 1 stop bit (1); line idles high. Delivers each word on a valid/ready output
//   with one-entry holding buffer; flags framing errors and overruns.
// PARAMETERS
//   DATA_W        8  data bits per frame (1..16)
//   CLKS_PER_BIT  4  clk cycles per serial bit (even, >=2); HALF = CLKS_PER_BIT/2
// PORTS
//   clk        in   1       rising-edge clock, sole clock
//   reset      in   1       asynchronous, active-low reset (0 = reset asserted)
//   din        in   1       serial line, registered in clk domain upstream (no synchronizer here)
//   dout       out  DATA_W  received word, stable while dout_valid=1
//   dout_valid out  1       word available; held until accepted
//   dout_ready in   1       consumer accept; transfer when dout_valid & dout_ready
//   frame_err  out  1       1-cycle pulse: stop bit sampled as 0
//   overrun    out  1       1-cycle pulse: completed word dropped, buffer still full
// BEHAVIOUR
//   Reset (reset=0, any time incl. mid-frame): state=IDLE, bit/clk counters=0, shift reg=0,
//     dout=0, dout_valid=0, frame_err=0, overrun=0; takes effect immediately, not on clk.
//   Registered outputs only; no combinational path from din or dout_ready to any output.
//   FSM (cnt = clk counter, idx = bit index):
//     IDLE  : din==0 -> START, cnt=0. Else stay.
//     START : cnt++; at cnt==HALF-1: din==0 -> DATA, cnt=0, idx=0; din==1 -> IDLE (glitch reject).
//     DATA  : cnt++; at cnt==CLKS_PER_BIT-1: shift din into MSB, shift right (LSB-first
//             assembly), cnt=0, idx++; after bit DATA_W-1 -> STOP.
//     STOP  : cnt++; at cnt==CLKS_PER_BIT-1 sample din:
//             din==1 -> IDLE; deliver word (see buffer rule).
//             din==0 -> BREAK; frame_err=1 next cycle; word discarded.
//     BREAK : stay until din==1, then IDLE (line held low must not retrigger frames).
//   Sampling: start verified HALF cycles after falling edge seen in IDLE; each later bit
//     sampled CLKS_PER_BIT cycles after previous sample (mid-bit).
//   Buffer rule at good stop sample (cycle S): if dout_valid==0, or dout_valid & dout_ready
//     in cycle S, then dout<=word and dout_valid<=1 at S+1; otherwise dout/dout_valid
//     unchanged and overrun=1 at S+1 (one cycle).
//   dout_valid clears the cycle after dout_valid & dout_ready unless reloaded in the same cycle.
//   frame_err and overrun never both 1; each is exactly one cycle wide.
//   Latency: dout_valid rises 1 clk after stop-bit sample = HALF+(DATA_W+1)*CLKS_PER_BIT+1
//     clks after IDLE first sees din==0 (defaults: 2+36+1 = 39).
//   Back-to-back frames: new start bit accepted in IDLE the cycle after STOP exit.
// TESTING (DATA_W=8, CLKS_PER_BIT=4, dout_ready=1 unless noted)
//   1 Reset low 20 ns mid-DATA of a frame -> dout=0, dout_valid=0, pulses 0; frame lost; next
//     clean 0x3C frame received correctly.
//   2 Send 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first) -> dout=0xA5, dout_valid high 1 cycle,
//     exactly 39 clks after din falls at IDLE; frame_err=0.
//   3 din low 1 cycle then high (glitch) -> FSM returns IDLE, no dout_valid, no frame_err;
//     following 0x5A frame received as 0x5A.
//   4 Send 0xFF with stop bit 0, hold din low 20 clks, then high -> frame_err one-cycle pulse,
//     no dout_valid, no spurious frame during low period; next 0x01 frame received.
//   5 dout_ready=0, send 0x11 then 0x22 -> dout=0x11 held valid, overrun pulse at 2nd stop;
//     raise dout_ready -> 0x11 accepted, dout_valid falls; 0x22 never appears.
//   6 Back-to-back 0x00 then 0x80 with 1-cycle idle gap -> both delivered in order.

Source files
------------

// File: rtl/serial_frame_rx_if.sv
// Output side of the serial deframer: received word on valid/ready plus error pulses.
interface serial_frame_rx_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              frame_err;
  logic              overrun;

  modport master (output dout, dout_valid, frame_err, overrun, input dout_ready);
  modport slave  (input dout, dout_valid, frame_err, overrun, output dout_ready);
endinterface

// File: rtl/serial_frame_rx.sv
// Serial deframer: start/DATA_W LSB-first data/stop, mid-bit sampling, one-entry
// output buffer with overrun and framing-error pulses. All outputs registered.
module serial_frame_rx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              din,
  serial_frame_rx_if.master rx
);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int IW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK
  } state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [IW-1:0]     idx, idx_nx;
  logic [DATA_W-1:0] sh, sh_nx;
  logic [DATA_W-1:0] dout_q, dout_nx;
  logic              vld_q, vld_nx;
  logic              ferr_q, ferr_nx;
  logic              ovr_q, ovr_nx;
  logic              load;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    sh_nx    = sh;
    ferr_nx  = 1'b0;
    ovr_nx   = 1'b0;
    load     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!din) begin
          state_nx = ST_START;
          cnt_nx   = '0;
        end
      end
      ST_START: begin
        if (cnt == CNT_HALF) begin
          cnt_nx = '0;
          idx_nx = '0;
          // start bit must still be low at mid-bit, otherwise it was a glitch
          state_nx = din ? ST_IDLE : ST_DATA;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt == CNT_BIT) begin
          cnt_nx = '0;
          sh_nx  = sh >> 1;
          sh_nx[DATA_W-1] = din;
          if (idx == IDX_LAST) begin
            idx_nx   = '0;
            state_nx = ST_STOP;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt == CNT_BIT) begin
          cnt_nx = '0;
          if (din) begin
            state_nx = ST_IDLE;
            // buffer is free if empty or being drained this very cycle
            if (!vld_q || rx.dout_ready) load = 1'b1;
            else                         ovr_nx = 1'b1;
          end else begin
            state_nx = ST_BREAK;
            ferr_nx  = 1'b1;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      ST_BREAK: begin
        // wait out a held-low line so it cannot look like a new start bit
        if (din) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    dout_nx = dout_q;
    vld_nx  = vld_q;
    if (load) begin
      dout_nx = sh_nx;
      vld_nx  = 1'b1;
    end else if (vld_q && rx.dout_ready) begin
      vld_nx = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      idx    <= '0;
      sh     <= '0;
      dout_q <= '0;
      vld_q  <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      idx    <= idx_nx;
      sh     <= sh_nx;
      dout_q <= dout_nx;
      vld_q  <= vld_nx;
      ferr_q <= ferr_nx;
      ovr_q  <= ovr_nx;
    end
  end

  assign rx.dout       = dout_q;
  assign rx.dout_valid = vld_q;
  assign rx.frame_err  = ferr_q;
  assign rx.overrun    = ovr_q;
endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: table of frames plus hand-written corner sequences,
// with a word scoreboard checked on every output handshake.
module tb_serial_frame_rx;
  localparam int DW  = 8;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic din = 1'b1;

  serial_frame_rx_if #(.DATA_W(DW)) rx_if();

  serial_frame_rx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .rx    (rx_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_vld;
    logic [7:0] exp_word;
    int         exp_ferr;
  } vec_t;

  vec_t       tbl [8];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q [$];
  logic [7:0] exp_w;
  int         ferr_cnt = 0;
  int         ovr_cnt = 0;
  logic       ferr_d = 1'b0;
  logic       ovr_d = 1'b0;
  int         f0, o0, lat_n;
  logic       lat_got;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    din = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(d[i], CPB);
    hold(stop, CPB);
  endtask

  // scoreboard and pulse monitor
  always @(negedge clk) begin
    if (reset) begin
      if (rx_if.dout_valid && rx_if.dout_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=0x%0h expected=none", rx_if.dout);
        end else begin
          exp_w = exp_q.pop_front();
          chk("word", {24'd0, rx_if.dout}, {24'd0, exp_w});
        end
      end
      if (rx_if.frame_err || rx_if.overrun)
        chk("err_ovr_exclusive", {31'd0, rx_if.frame_err & rx_if.overrun}, 32'd0);
      if (rx_if.frame_err) begin
        chk("ferr_one_cycle", {31'd0, ferr_d}, 32'd0);
        ferr_cnt++;
      end
      if (rx_if.overrun) begin
        chk("ovr_one_cycle", {31'd0, ovr_d}, 32'd0);
        ovr_cnt++;
      end
      ferr_d = rx_if.frame_err;
      ovr_d  = rx_if.overrun;
    end else begin
      ferr_d = 1'b0;
      ovr_d  = 1'b0;
    end
  end

  initial begin
    tbl[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 0};
    tbl[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
    tbl[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};
    tbl[3] = '{8'h7E, 1'b0, 1'b0, 8'h00, 1};
    tbl[4] = '{8'h81, 1'b1, 1'b1, 8'h81, 0};
    tbl[5] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 0};
    tbl[6] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 0};
    tbl[7] = '{8'h01, 1'b1, 1'b1, 8'h01, 0};

    rx_if.dout_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout",  {24'd0, rx_if.dout}, 32'd0);
    chk("rst_valid", {31'd0, rx_if.dout_valid}, 32'd0);
    chk("rst_ferr",  {31'd0, rx_if.frame_err}, 32'd0);
    chk("rst_ovr",   {31'd0, rx_if.overrun}, 32'd0);
    reset = 1'b1;
    hold(1'b1, 4);

    // table-driven frames
    for (int k = 0; k < 8; k++) begin
      f0 = ferr_cnt;
      o0 = ovr_cnt;
      if (tbl[k].exp_vld) exp_q.push_back(tbl[k].exp_word);
      send_frame(tbl[k].data, tbl[k].stop);
      hold(1'b1, 6);
      chk("tbl_ferr", ferr_cnt - f0, tbl[k].exp_ferr);
      chk("tbl_ovr", ovr_cnt - o0, 0);
      chk("tbl_drain", exp_q.size(), 0);
    end

    // latency from falling edge to dout_valid, valid lasts one cycle
    exp_q.push_back(8'hA5);
    lat_n = 0;
    lat_got = 1'b0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (!lat_got && lat_n < 100) begin
          @(posedge clk);
          lat_n++;
          #1;
          if (rx_if.dout_valid) lat_got = 1'b1;
        end
        chk("latency", lat_n, 39);
        @(posedge clk);
        #1;
        chk("valid_one_cycle", {31'd0, rx_if.dout_valid}, 32'd0);
      end
    join
    hold(1'b1, 4);
    chk("lat_drain", exp_q.size(), 0);

    // reset mid-DATA: all-ones payload so the remainder of the line stays high
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (14) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrst_dout",  {24'd0, rx_if.dout}, 32'd0);
        chk("midrst_valid", {31'd0, rx_if.dout_valid}, 32'd0);
        chk("midrst_ferr",  {31'd0, rx_if.frame_err}, 32'd0);
        chk("midrst_ovr",   {31'd0, rx_if.overrun}, 32'd0);
        #17 reset = 1'b1;
      end
    join
    hold(1'b1, 4);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    hold(1'b1, 6);
    chk("post_rst_drain", exp_q.size(), 0);

    // one-cycle glitch on an idle line
    f0 = ferr_cnt;
    hold(1'b0, 1);
    hold(1'b1, 8);
    chk("glitch_ferr", ferr_cnt - f0, 0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    hold(1'b1, 6);
    chk("glitch_drain", exp_q.size(), 0);

    // bad stop bit followed by a long break
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    send_frame(8'hFF, 1'b0);
    hold(1'b0, 20);
    hold(1'b1, 4);
    chk("break_ferr", ferr_cnt - f0, 1);
    chk("break_ovr", ovr_cnt - o0, 0);
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1);
    hold(1'b1, 6);
    chk("break_drain", exp_q.size(), 0);

    // overrun with a stalled consumer
    rx_if.dout_ready = 1'b0;
    o0 = ovr_cnt;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    hold(1'b1, 2);
    send_frame(8'h22, 1'b1);
    hold(1'b1, 4);
    chk("ovr_pulse", ovr_cnt - o0, 1);
    chk("ovr_dout", {24'd0, rx_if.dout}, 32'h11);
    chk("ovr_valid", {31'd0, rx_if.dout_valid}, 32'd1);
    rx_if.dout_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("ovr_valid_fall", {31'd0, rx_if.dout_valid}, 32'd0);
    hold(1'b1, 4);
    chk("ovr_drain", exp_q.size(), 0);

    // back-to-back frames with one idle cycle between
    exp_q.push_back(8'h00);
    send_frame(8'h00, 1'b1);
    hold(1'b1, 1);
    exp_q.push_back(8'h80);
    send_frame(8'h80, 1'b1);
    hold(1'b1, 6);
    chk("b2b_drain", exp_q.size(), 0);

    chk("total_ferr", ferr_cnt, 2);
    chk("total_ovr", ovr_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
